// File: rtl/snf_txdat_ll.sv
// SNF TXDAT link-layer transmitter: round-robin source arbitration,
// L-credit accounting and credit return on link deactivation.
`ifndef CHIE_DAT_FLIT_WIDTH
`define CHIE_DAT_FLIT_WIDTH 392
`endif

module snf_txdat_ll #(
  parameter int FLIT_W  = `CHIE_DAT_FLIT_WIDTH,
  parameter int NUM_SRC = 2,
  parameter int MAX_CRD = 15,
  parameter int CRD_W   = $clog2(MAX_CRD+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      txdat_lcrdv,
  input  logic                      txdat_link_active,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*FLIT_W-1:0] src_flit,
  output logic [NUM_SRC-1:0]        src_won,
  output logic                      txdatflitv,
  output logic [FLIT_W-1:0]         txdatflit,
  output logic                      txdatflitpend,
  output logic [CRD_W-1:0]          crd_cnt,
  output logic                      crd_ret_done,
  output logic                      crd_ovf_err
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    ST_STOP,
    ST_RUN,
    ST_RETURN
  } state_e;

  state_e             state_q, state_d;
  logic [CRD_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic               fv_q, fv_d;
  logic [FLIT_W-1:0]  flit_q, flit_d;
  logic               pend_q;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  logic               crd_avail;
  logic               found;
  logic [PTR_W-1:0]   win_idx;
  logic               grant;
  logic               ret_send;
  logic               send;
  logic [NUM_SRC-1:0] won;
  logic [FLIT_W-1:0]  win_flit;

  assign crd_avail = txdat_lcrdv | (cnt_q != '0);

  // First valid source at or after rr_q, wrapping.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!found && src_valid[i] &&
            ((int'(rr_q) + k == i) ||
             (int'(rr_q) + k == i + NUM_SRC))) begin
          found   = 1'b1;
          win_idx = PTR_W'(i);
        end
      end
    end
  end

  assign grant    = (state_q == ST_RUN) && crd_avail && found;
  assign ret_send = (state_q == ST_RETURN) && crd_avail;
  assign send     = grant | ret_send;

  always_comb begin
    won      = '0;
    win_flit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      won[i] = grant && (win_idx == PTR_W'(i));
      if (won[i]) begin
        win_flit = win_flit | src_flit[i*FLIT_W +: FLIT_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STOP: begin
        if (txdat_link_active) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!txdat_link_active) state_d = ST_RETURN;
      end
      ST_RETURN: begin
        if ((cnt_q == '0) && !txdat_lcrdv) state_d = ST_STOP;
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    rr_d   = rr_q;
    fv_d   = send;
    flit_d = grant ? win_flit : '0;
    done_d = (state_q == ST_RETURN) && (state_d == ST_STOP);
    if (txdat_lcrdv && !send) begin
      if (cnt_q == CRD_W'(MAX_CRD)) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CRD_W'(1);
      end
    end else if (send && !txdat_lcrdv) begin
      cnt_d = cnt_q - CRD_W'(1);
    end
    if (grant) begin
      if (win_idx == PTR_W'(NUM_SRC-1)) begin
        rr_d = '0;
      end else begin
        rr_d = win_idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STOP;
      cnt_q   <= '0;
      rr_q    <= '0;
      fv_q    <= 1'b0;
      flit_q  <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      fv_q    <= fv_d;
      flit_q  <= flit_d;
      pend_q  <= (state_q != ST_STOP);
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign src_won       = won;
  assign txdatflitv    = fv_q;
  assign txdatflit     = flit_q;
  assign txdatflitpend = pend_q;
  assign crd_cnt       = cnt_q;
  assign crd_ret_done  = done_q;
  assign crd_ovf_err   = ovf_q;

endmodule

// File: tb/tb_snf_txdat_ll.sv
// Bench for snf_txdat_ll: per-cycle vector table, expected
// link flits queued at drive time and popped after the edge.
module tb_snf_txdat_ll;

  localparam int FW = 16;
  localparam int NS = 3;
  localparam int MC = 15;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          lcrdv;
  logic          act;
  logic [NS-1:0] vld;
  logic [NS*FW-1:0] flits;
  logic [NS-1:0] won;
  logic          fv;
  logic [FW-1:0] flit;
  logic          pend;
  logic [CW-1:0] cnt;
  logic          done;
  logic          ovf;

  snf_txdat_ll #(
    .FLIT_W (FW),
    .NUM_SRC(NS),
    .MAX_CRD(MC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .txdat_lcrdv      (lcrdv),
    .txdat_link_active(act),
    .src_valid        (vld),
    .src_flit         (flits),
    .src_won          (won),
    .txdatflitv       (fv),
    .txdatflit        (flit),
    .txdatflitpend    (pend),
    .crd_cnt          (cnt),
    .crd_ret_done     (done),
    .crd_ovf_err      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       r;
    logic       l;
    logic       a;
    logic [2:0] v;
    logic [2:0] w;
    logic       fv;
    logic [3:0] c;
    logic       p;
    logic       d;
    logic       o;
  } vec_t;

  typedef struct packed {
    logic          v;
    logic [FW-1:0] f;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic l, input logic a,
                     input logic [2:0] v, input logic [2:0] w,
                     input logic f, input int c, input logic p,
                     input logic d, input logic o);
    vec_t e;
    e = '{r: r, l: l, a: a, v: v, w: w, fv: f,
          c: 4'(c), p: p, d: d, o: o};
    tbl.push_back(e);
  endtask

  task automatic chk(input string nm, input int row,
                     input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h",
               nm, row, act_v, exp_v);
    end
  endtask

  function automatic logic [FW-1:0] src_val(input int s, input int row);
    return FW'(((s + 1) << 12) | (row & 12'hfff));
  endfunction

  initial begin
    exp_t ex;
    exp_t got;
    vec_t t;

    // reset, STOP ignores requests, link up
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 7, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    // six credits, no requests
    for (int i = 1; i <= 6; i++) add(0, 1, 1, 0, 0, 0, i, 1, 0, 0);
    // all valid: grants 0,1,2,0,1,2
    for (int i = 0; i < 6; i++)
      add(0, 0, 1, 7, 3'(1 << (i % 3)), 1, 5 - i, 1, 0, 0);
    add(0, 0, 1, 7, 0, 0, 0, 1, 0, 0);
    // zero count, credit every other cycle, rr wrap
    add(0, 1, 1, 2, 2, 1, 0, 1, 0, 0);
    add(0, 0, 1, 2, 0, 0, 0, 1, 0, 0);
    add(0, 1, 1, 2, 2, 1, 0, 1, 0, 0);
    add(0, 0, 1, 2, 0, 0, 0, 1, 0, 0);
    add(0, 1, 1, 1, 1, 1, 0, 1, 0, 0);
    add(0, 1, 1, 5, 4, 1, 0, 1, 0, 0);
    // five credits; grant in the cycle link falls leaves four
    for (int i = 1; i <= 5; i++) add(0, 1, 1, 0, 0, 0, i, 1, 0, 0);
    add(0, 0, 0, 1, 1, 1, 4, 1, 0, 0);
    // RETURN: lcrdv on first cycle -> five zero flits
    add(0, 1, 0, 7, 0, 1, 4, 1, 0, 0);
    for (int c = 3; c >= 0; c--) add(0, 0, 1, 7, 0, 1, c, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // fill to MAX_CRD in STOP, then overflow, sticky
    for (int i = 1; i <= MC; i++) add(0, 1, 0, 0, 0, 0, i, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 15, 0, 0, 1);
    add(0, 0, 0, 7, 0, 0, 15, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 15, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 15, 1, 0, 1);
    for (int c = 14; c >= 3; c--) add(0, 0, 0, 0, 0, 1, c, 1, 0, 1);
    // reset in RETURN with three credits held
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 7, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst   = 1'b1;
    lcrdv = 1'b0;
    act   = 1'b0;
    vld   = '0;
    flits = '0;
    @(posedge clk);
    #1;

    for (int k = 0; k < tbl.size(); k++) begin
      t = tbl[k];
      rst   = t.r;
      lcrdv = t.l;
      act   = t.a;
      vld   = t.v;
      for (int s = 0; s < NS; s++) flits[s*FW +: FW] = src_val(s, k);
      #3;
      chk("src_won", k, 32'(won), 32'(t.w));
      ex.v = t.fv;
      ex.f = '0;
      for (int s = 0; s < NS; s++)
        if (t.w[s]) ex.f = src_val(s, k);
      sb.push_back(ex);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk("flitv", k, 32'(fv), 32'(got.v));
      chk("flit", k, 32'(flit), 32'(got.f));
      chk("crd_cnt", k, 32'(cnt), 32'(t.c));
      chk("flitpend", k, 32'(pend), 32'(t.p));
      chk("ret_done", k, 32'(done), 32'(t.d));
      chk("ovf_err", k, 32'(ovf), 32'(t.o));
    end

    // hand sequence: saturated count with simultaneous inc+dec holds
    rst = 1'b0;
    act = 1'b1;
    vld = '0;
    lcrdv = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk);
      #1;
    end
    chk("sat_cnt", 900, 32'(cnt), 32'(MC));
    chk("sat_ovf", 901, 32'(ovf), 32'd1);
    vld = 3'b001;
    @(posedge clk);
    #1;
    chk("incdec_cnt", 902, 32'(cnt), 32'(MC));
    chk("incdec_fv", 903, 32'(fv), 32'd1);
    chk("incdec_flit", 904, 32'(flit), 32'(flits[FW-1:0]));
    lcrdv = 1'b0;
    vld   = '0;
    @(posedge clk);
    #1;
    chk("idle_fv", 905, 32'(fv), 32'd0);
    chk("ovf_hold", 906, 32'(ovf), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
